seq_calculator: RTL and testbench

SEQ_CALCULATOR -- requirements
Module: seq_calculator

---
 rtl/seq_calculator.sv | 158 +++++++++++++++
 tb/tb_seq_calculator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_calculator.sv
// Unsigned sequential calculator: ADD/SUB/DIV-by-zero finish one cycle after accept, MUL/DIV after WIDTH+1.
// No backpressure queue: start is taken only in IDLE and silently dropped while busy.
module seq_calculator #(
    parameter int WIDTH      = 32,
    parameter bit IDLE_CLEAR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           operation,
    input  logic [WIDTH-1:0]     first_input_number,
    input  logic [WIDTH-1:0]     second_input_number,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    // Bit WIDTH of the (WIDTH+1)-bit difference is exactly the borrow.
    always_comb begin
        add_sum  = {1'b0, first_input_number} + {1'b0, second_input_number};
        sub_diff = {1'b0, first_input_number} - {1'b0, second_input_number};
    end

    // MUL: work_q = {partial product high half, unconsumed multiplier bits}, opnd_q = multiplicand.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
    end

    // DIV: work_q = {partial remainder, dividend shifting into quotient}, opnd_q = divisor.
    always_comb begin
        div_ge   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]} >= {1'b0, opnd_q};
        div_diff = {work_q[2*WIDTH-2:WIDTH], work_q[WIDTH-1]} - opnd_q;
        div_next = div_ge ? {div_diff, work_q[WIDTH-2:0], 1'b1}
                          : {work_q[2*WIDTH-2:0], 1'b0};
        step_next = (op_q == OP_MUL) ? mul_next : div_next;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        work_d   = work_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = operation;
                    dbz_d = 1'b0;
                    cnt_d = '0;
                    if (IDLE_CLEAR) begin
                        result_d = '0;
                    end
                    case (operation)
                        OP_ADD: begin
                            result_d = {{(WIDTH-1){1'b0}}, add_sum};
                            state_d  = S_FINISH;
                        end
                        OP_SUB: begin
                            result_d = {{(WIDTH-1){1'b0}}, sub_diff};
                            state_d  = S_FINISH;
                        end
                        OP_MUL: begin
                            opnd_d  = first_input_number;
                            work_d  = {{WIDTH{1'b0}}, second_input_number};
                            state_d = S_RUN;
                        end
                        default: begin
                            if (second_input_number == '0) begin
                                result_d = '0;
                                dbz_d    = 1'b1;
                                state_d  = S_FINISH;
                            end else begin
                                opnd_d  = second_input_number;
                                work_d  = {{WIDTH{1'b0}}, first_input_number};
                                state_d = S_RUN;
                            end
                        end
                    endcase
                end
            end
            S_RUN: begin
                work_d = step_next;
                if (cnt_q == LAST_STEP) begin
                    result_d = step_next;
                    cnt_d    = '0;
                    state_d  = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Scoreboard bench for seq_calculator at WIDTH 8, 16 (IDLE_CLEAR=1) and 32.
// Stimulus pushes expected {result, div_by_zero, done cycle}; a monitor pops on every done pulse.
module tb_seq_calculator;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef struct packed {
        logic [63:0] res;
        logic        dbz;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  dbz_v;
    logic [15:0] res8;
    logic [31:0] res16;
    logic [63:0] res32;
    logic [63:0] res_v [3];

    exp_t exp_q [3][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    seq_calculator #(.WIDTH(8), .IDLE_CLEAR(1'b0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .operation(op),
        .first_input_number(a[7:0]), .second_input_number(b[7:0]),
        .busy(busy_v[0]), .done(done_v[0]), .result(res8), .div_by_zero(dbz_v[0])
    );
    seq_calculator #(.WIDTH(16), .IDLE_CLEAR(1'b1)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .operation(op),
        .first_input_number(a[15:0]), .second_input_number(b[15:0]),
        .busy(busy_v[1]), .done(done_v[1]), .result(res16), .div_by_zero(dbz_v[1])
    );
    seq_calculator #(.WIDTH(32), .IDLE_CLEAR(1'b0)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .operation(op),
        .first_input_number(a), .second_input_number(b),
        .busy(busy_v[2]), .done(done_v[2]), .result(res32), .div_by_zero(dbz_v[2])
    );

    assign res_v[0] = {48'd0, res8};
    assign res_v[1] = {32'd0, res16};
    assign res_v[2] = res32;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one request; done is expected 'lat' cycles after the accept edge.
    task automatic issue(input int idx, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] er, input logic ed,
                         input int lat);
        exp_t e;
        @(negedge clk);
        op = o;
        a  = av;
        b  = bv;
        start_v[idx] = 1'b1;
        e.res = er;
        e.dbz = ed;
        e.cyc = 32'(cyc + lat);
        exp_q[idx].push_back(e);
        @(posedge clk);
        #1 start_v[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, output int nb);
        bit fin;
        int k;
        fin = 1'b0;
        k   = 0;
        nb  = 0;
        while (!fin && k < 200) begin
            @(negedge clk);
            #1;
            if (busy_v[idx]) nb++;
            if (exp_q[idx].size() == 0 && !busy_v[idx]) fin = 1'b1;
            k++;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: got no done within 200 cycles want done", idx);
            exp_q[idx].delete();
        end
    endtask

    initial begin
        int nb;
        bit seen;
        int k;
        rst_n   = 1'b0;
        start_v = 3'b000;
        op      = OP_ADD;
        a       = '0;
        b       = '0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst_n) begin
                    for (int i = 0; i < 3; i++) begin
                        if (done_v[i]) begin
                            if (exp_q[i].size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL spurious_done dut%0d: got done=1 want done=0 at cycle %0d", i, cyc);
                            end else begin
                                e = exp_q[i].pop_front();
                                chk($sformatf("result_dut%0d", i), res_v[i], e.res);
                                chk($sformatf("div_by_zero_dut%0d", i), 64'(dbz_v[i]), 64'(e.dbz));
                                chk($sformatf("done_cycle_dut%0d", i), 64'(cyc), 64'(e.cyc));
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_result_dut%0d", i), res_v[i], 64'd0);
            chk($sformatf("reset_flags_dut%0d", i), 64'({busy_v[i], done_v[i], dbz_v[i]}), 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // WIDTH=8: first request lands on the first edge after reset release
        issue(0, OP_ADD, 32'hFF, 32'h01, 64'h0100, 1'b0, 1);
        wait_done(0, nb);
        chk("add_busy_cycles", 64'(nb), 64'd1);
        issue(0, OP_SUB, 32'h03, 32'h05, 64'h01FE, 1'b0, 1);
        wait_done(0, nb);

        // MUL with start held high through RUN and the done cycle; inputs changed too
        issue(0, OP_MUL, 32'hFF, 32'hFF, 64'hFE01, 1'b0, 9);
        op = OP_ADD;
        a  = 32'h1;
        b  = 32'h1;
        start_v[0] = 1'b1;
        seen = 1'b0;
        nb = 0;
        k  = 0;
        while (!seen && k < 50) begin
            @(negedge clk);
            #1;
            if (busy_v[0]) nb++;
            if (done_v[0]) seen = 1'b1;
            k++;
        end
        chk("mul_busy_cycles", 64'(nb), 64'd9);
        @(negedge clk);
        start_v[0] = 1'b0;
        #1 chk("start_during_done_ignored", 64'(busy_v[0]), 64'd0);

        issue(0, OP_DIV, 32'd100, 32'd7, 64'h020E, 1'b0, 9);
        repeat (3) @(negedge clk);
        chk("result_holds_during_run", res_v[0], 64'hFE01);
        wait_done(0, nb);
        issue(0, OP_DIV, 32'd7, 32'd100, 64'h0700, 1'b0, 9);
        wait_done(0, nb);
        chk("div_busy_cycles", 64'(nb), 64'd9);
        issue(0, OP_DIV, 32'd5, 32'd0, 64'h0, 1'b1, 1);
        wait_done(0, nb);
        chk("div0_busy_cycles", 64'(nb), 64'd1);
        repeat (3) @(negedge clk);
        chk("div_by_zero_sticky", 64'(dbz_v[0]), 64'd1);
        issue(0, OP_ADD, 32'd1, 32'd2, 64'h3, 1'b0, 1);
        wait_done(0, nb);

        // WIDTH=16, IDLE_CLEAR=1: operands churn every cycle during the divide
        issue(1, OP_ADD, 32'h1234, 32'h0001, 64'h1235, 1'b0, 1);
        wait_done(1, nb);
        issue(1, OP_DIV, 32'd1000, 32'd10, 64'h0000_0064, 1'b0, 17);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            if (j == 2) chk("idle_clear_result", res_v[1], 64'd0);
        end
        wait_done(1, nb);
        issue(1, OP_MUL, 32'hFFFF, 32'hFFFF, 64'hFFFE_0001, 1'b0, 17);
        wait_done(1, nb);
        chk("mul16_busy_cycles", 64'(nb), 64'd17);

        // WIDTH=32
        issue(2, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 33);
        wait_done(2, nb);
        chk("mul32_busy_cycles", 64'(nb), 64'd33);
        issue(2, OP_SUB, 32'd0, 32'd1, 64'h1_FFFF_FFFF, 1'b0, 1);
        wait_done(2, nb);

        // Abort a MUL with reset at cycle 10 after accept
        issue(2, OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 1'b0, 33);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q[2].delete();
        #1;
        chk("abort_result", res_v[2], 64'd0);
        chk("abort_flags", 64'({busy_v[2], done_v[2], dbz_v[2]}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_idle_after_release", 64'(busy_v[2]), 64'd0);
        issue(2, OP_ADD, 32'd2, 32'd3, 64'd5, 1'b0, 1);
        wait_done(2, nb);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
